// File: rtl/radix4_digit_sequencer.sv
// radix4_digit_sequencer
//   Recodes a multiplier operand into radix-4 (modified Booth) digits in the
//   set {-2,-1,0,+1,+2}. Digits are emitted LSB first over a valid/ready
//   handshake; digit i carries weight 4^i.
//
// Ports
//   clk          clock, all state changes on its rising edge
//   rst          asynchronous active-high reset
//   start        begin recoding y_in (accepted only while ready)
//   y_in         multiplier operand, captured with an accepted start
//   y_signed     1 = y_in is two's complement, 0 = unsigned
//   abort        cancel the current transaction (wins over start/handshake)
//   ready        idle and able to accept start
//   digit_valid  a digit is presented on digit_*
//   digit_ready  consumer takes the presented digit this cycle
//   digit_mag    digit magnitude 0..2
//   digit_neg    digit sign, never set for a zero digit
//   digit_idx    digit position i
//   digit_last   presented digit is the final one
//   done         one-cycle pulse after the final digit is taken
module radix4_digit_sequencer #(
  parameter int Y_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [Y_WIDTH-1:0]    y_in,
  input  logic                  y_signed,
  input  logic                  abort,
  output logic                  ready,
  output logic                  digit_valid,
  input  logic                  digit_ready,
  output logic [1:0]            digit_mag,
  output logic                  digit_neg,
  output logic [((Y_WIDTH/2+1) > 1 ? $clog2(Y_WIDTH/2+1) : 1)-1:0] digit_idx,
  output logic                  digit_last,
  output logic                  done
);

  localparam int NUM_DIGITS = Y_WIDTH / 2 + 1;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int EXT_W      = 2 * NUM_DIGITS;
  localparam int SR_W       = EXT_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state, w_state_next;
  logic [SR_W-1:0]   r_sr, w_sr_next;
  logic [IDX_W-1:0]  r_idx, w_idx_next;

  logic              w_sign;
  logic [EXT_W-1:0]  w_ext;
  logic              w_valid;
  logic              w_last;
  logic              w_hs;
  logic [1:0]        w_mag;
  logic              w_neg;

  // Operand extended to an even number of bits with room for one extra
  // digit, so the top triple always sees the true sign (or a zero for
  // unsigned operands).
  assign w_sign  = y_signed & y_in[Y_WIDTH-1];
  assign w_ext   = {{(EXT_W - Y_WIDTH){w_sign}}, y_in};

  assign w_valid = (r_state == S_EMIT);
  assign w_last  = w_valid && (r_idx == LAST_IDX);
  assign w_hs    = w_valid && digit_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_sr    <= w_sr_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sr_next    = r_sr;
    w_idx_next   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (!abort && start) begin
          w_state_next = S_EMIT;
          w_sr_next    = {w_ext, 1'b0};  // y[-1] = 0 below the LSB
          w_idx_next   = '0;
        end
      end
      S_EMIT: begin
        if (abort) begin
          w_state_next = S_IDLE;
          w_sr_next    = '0;
          w_idx_next   = '0;
        end else if (w_hs) begin
          if (w_last) begin
            // Index stays on the final digit; the register is not needed.
            w_state_next = S_DONE;
          end else begin
            w_sr_next  = {2'b00, r_sr[SR_W-1:2]};
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Booth recoding of the triple (y[2i+1], y[2i], y[2i-1]).
  always_comb begin
    w_mag = 2'd0;
    w_neg = 1'b0;
    case (r_sr[2:0])
      3'b001, 3'b010: begin w_mag = 2'd1; w_neg = 1'b0; end
      3'b011:         begin w_mag = 2'd2; w_neg = 1'b0; end
      3'b100:         begin w_mag = 2'd2; w_neg = 1'b1; end
      3'b101, 3'b110: begin w_mag = 2'd1; w_neg = 1'b1; end
      default:        begin w_mag = 2'd0; w_neg = 1'b0; end
    endcase
  end

  assign ready       = (r_state == S_IDLE);
  assign digit_valid = w_valid;
  assign digit_mag   = w_valid ? w_mag : 2'd0;
  assign digit_neg   = w_valid & w_neg;
  assign digit_idx   = w_valid ? r_idx : '0;
  assign digit_last  = w_last;
  // An abort arriving in the done cycle suppresses the pulse.
  assign done        = (r_state == S_DONE) && !abort;

endmodule

// File: tb/tb_radix4_digit_sequencer.sv
// Testbench for radix4_digit_sequencer (Y_WIDTH = 8, five digits).
module tb_radix4_digit_sequencer;

  localparam int YW = 8;
  localparam int ND = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [YW-1:0] y_in;
  logic          y_signed;
  logic          abort;
  logic          ready;
  logic          digit_valid;
  logic          digit_ready;
  logic [1:0]    digit_mag;
  logic          digit_neg;
  logic [2:0]    digit_idx;
  logic          digit_last;
  logic          done;

  int tests_run    = 0;
  int tests_failed = 0;

  radix4_digit_sequencer #(.Y_WIDTH(YW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .y_in        (y_in),
    .y_signed    (y_signed),
    .abort       (abort),
    .ready       (ready),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .digit_mag   (digit_mag),
    .digit_neg   (digit_neg),
    .digit_idx   (digit_idx),
    .digit_last  (digit_last),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  y;
    logic        s;
    logic [14:0] dig;   // five 3-bit signed digits, digit 0 in the LSBs
    string       name;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [14:0] pack5(input int a0, input int a1, input int a2,
                                        input int a3, input int a4);
    return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  function automatic int unpk(input logic [14:0] p, input int i);
    logic [2:0] t;
    t = p[3*i +: 3];
    return int'($signed(t));
  endfunction

  function automatic int dval();
    return digit_neg ? -int'(digit_mag) : int'(digit_mag);
  endfunction

  // Reference model: numeric value of the operand, and Booth digits
  // d_i = y[2i-1] + y[2i] - 2*y[2i+1] taken from its two's-complement bits.
  function automatic longint op_value(input logic [7:0] y, input logic s);
    return s ? longint'($signed(y)) : longint'(y);
  endfunction

  function automatic int ybit(input longint v, input int k);
    if (k < 0) return 0;
    return int'((v >>> k) & 64'sd1);
  endfunction

  function automatic logic [14:0] ref_digits(input logic [7:0] y, input logic s);
    longint v;
    int d [ND];
    v = op_value(y, s);
    for (int i = 0; i < ND; i++)
      d[i] = ybit(v, 2*i-1) + ybit(v, 2*i) - 2*ybit(v, 2*i+1);
    return pack5(d[0], d[1], d[2], d[3], d[4]);
  endfunction

  // One transaction with digit_ready high except for an optional stall.
  task automatic do_txn(input logic [7:0] y, input logic s, input logic [14:0] exp,
                        input int stall_at, input int stall_len, input string tag);
    @(negedge clk);
    chk({tag, " ready_before_start"}, ready, 1);
    start = 1'b1; y_in = y; y_signed = s; digit_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; y_in = 8'($urandom); y_signed = 1'($urandom);
    for (int i = 0; i < ND; i++) begin
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          digit_ready = 1'b0;
          chk({tag, " stall_valid"}, digit_valid, 1);
          chk({tag, " stall_idx"},   digit_idx, i);
          chk({tag, " stall_digit"}, dval(), unpk(exp, i));
          @(negedge clk);
        end
      end
      digit_ready = 1'b1;
      chk({tag, " valid"}, digit_valid, 1);
      chk({tag, " idx"},   digit_idx, i);
      chk({tag, " digit"}, dval(), unpk(exp, i));
      chk({tag, " last"},  digit_last, (i == ND-1));
      chk({tag, " ready_busy"}, ready, 0);
      chk({tag, " done_early"}, done, 0);
      if (digit_mag == 2'd0) chk({tag, " neg_on_zero"}, digit_neg, 0);
      @(negedge clk);
    end
    chk({tag, " done"},          done, 1);
    chk({tag, " valid_in_done"}, digit_valid, 0);
    chk({tag, " ready_in_done"}, ready, 0);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, done, 0);
    chk({tag, " ready_after"},    ready, 1);
  endtask

  vec_t vecs [7];

  initial begin
    longint sum;
    int     n;
    bit     got_done;
    bit     rdy;
    logic [7:0]  ry;
    logic        rs;
    logic [14:0] rexp;

    vecs[0] = '{8'hFF, 1'b0, pack5(-1, 0, 0, 0,  1), "ff_unsigned"};
    vecs[1] = '{8'hFF, 1'b1, pack5(-1, 0, 0, 0,  0), "ff_signed"};
    vecs[2] = '{8'h80, 1'b1, pack5( 0, 0, 0,-2,  0), "80_signed"};
    vecs[3] = '{8'h00, 1'b0, pack5( 0, 0, 0, 0,  0), "zero"};
    vecs[4] = '{8'h01, 1'b0, pack5( 1, 0, 0, 0,  0), "one"};
    vecs[5] = '{8'h55, 1'b0, pack5( 1, 1, 1, 1,  0), "55_unsigned"};
    vecs[6] = '{8'h7F, 1'b1, pack5(-1, 0, 0, 2,  0), "7f_signed"};

    rst = 1'b1; start = 1'b0; y_in = '0; y_signed = 1'b0;
    abort = 1'b0; digit_ready = 1'b1;

    #3;
    chk("reset ready", ready, 1);
    chk("reset valid", digit_valid, 0);
    chk("reset mag",   digit_mag, 0);
    chk("reset neg",   digit_neg, 0);
    chk("reset last",  digit_last, 0);
    chk("reset done",  done, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    foreach (vecs[v]) do_txn(vecs[v].y, vecs[v].s, vecs[v].dig, -1, 0, vecs[v].name);

    // Backpressure: three stalled cycles while idx = 2
    do_txn(8'hFF, 1'b0, pack5(-1, 0, 0, 0, 1), 2, 3, "stall_idx2");

    // abort wins over start in IDLE
    @(negedge clk);
    start = 1'b1; abort = 1'b1; y_in = 8'h33;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_over_start ready", ready, 1);
    chk("abort_over_start valid", digit_valid, 0);

    // Abort at idx = 3, restart two cycles later with 0x01
    @(negedge clk);
    start = 1'b1; y_in = 8'hFF; y_signed = 1'b0; digit_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort idx_before", digit_idx, 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort valid_dropped", digit_valid, 0);
    chk("abort ready",         ready, 1);
    chk("abort no_done",       done, 0);
    do_txn(8'h01, 1'b0, pack5(1, 0, 0, 0, 0), -1, 0, "after_abort");

    // start held during EMIT is ignored; then reset pulse at idx = 1
    @(negedge clk);
    start = 1'b1; y_in = 8'h01; y_signed = 1'b0; digit_ready = 1'b1;
    @(negedge clk);
    y_in = 8'hAA;   // start stays high
    chk("held_start d0", dval(), 1);
    chk("held_start idx0", digit_idx, 0);
    @(negedge clk);
    chk("held_start idx1", digit_idx, 1);
    chk("held_start d1", dval(), 0);
    chk("held_start ready", ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid ready", ready, 1);
    chk("rst_mid valid", digit_valid, 0);
    chk("rst_mid idx",   digit_idx, 0);
    chk("rst_mid mag",   digit_mag, 0);
    chk("rst_mid last",  digit_last, 0);
    chk("rst_mid done",  done, 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_txn(8'h80, 1'b1, pack5(0, 0, 0, -2, 0), -1, 0, "after_reset");

    // Randomized transactions with random backpressure
    for (int t = 0; t < 40; t++) begin
      ry = 8'($urandom); rs = 1'($urandom);
      rexp = ref_digits(ry, rs);
      @(negedge clk);
      start = 1'b1; y_in = ry; y_signed = rs;
      @(negedge clk);
      start = 1'b0;
      n = 0; sum = 0; got_done = 1'b0;
      for (int c = 0; c < 100 && !got_done; c++) begin
        rdy = ($urandom_range(0, 3) != 0);
        digit_ready = rdy;
        if (done) begin
          got_done = 1'b1;
          chk("rand digit_count", n, ND);
          chk("rand sum", sum, op_value(ry, rs));
        end else begin
          if (digit_valid) begin
            chk("rand idx", digit_idx, n);
            chk("rand digit", dval(), unpk(rexp, n));
            chk("rand last", digit_last, (n == ND-1));
            if (rdy) begin
              sum += longint'(dval()) * (longint'(1) << (2*n));
              n++;
            end
          end
          @(negedge clk);
        end
      end
      if (!got_done) chk("rand done_timeout", 0, 1);
    end
    digit_ready = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
